// File: rtl/loop_sram_ctrl.sv
// Looper controller: sequences an external 16-bit SRAM to record, play back and
// overdub an audio loop, one fixed-timing SRAM access phase per sample strobe.
module loop_sram_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int MAX_LEN    = 1048576,
  parameter int ACCESS_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sample_valid,
  input  logic [15:0]       i_data,
  input  logic              i_rec_toggle,
  input  logic              i_odub_toggle,
  input  logic              i_clear,
  output logic [15:0]       o_data,
  output logic              o_valid,
  output logic [1:0]        o_state,
  output logic [ADDR_W:0]   o_loop_len,
  output logic              o_loop_start,
  output logic              o_overrun,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq_in,
  output logic              o_sram_we_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int CNT_W = (ACCESS_CYC > 2) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_PREV = CNT_W'(ACCESS_CYC - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]  ADDR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]  MAX_LEN_V = (ADDR_W+1)'(MAX_LEN);

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_RECORD = 2'd1,
    M_PLAY   = 2'd2,
    M_ODUB   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_READ  = 2'd1,
    A_WRITE = 2'd2
  } acc_t;

  // Two's-complement add of two 16-bit words, clamped to the 16-bit range.
  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) begin
      sat16 = s[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat16 = s[15:0];
    end
  endfunction

  mode_t                  r_mode;
  acc_t                   r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W:0]        r_addr;
  logic [ADDR_W:0]        r_loop_len;
  logic                   r_rec_pend;
  logic                   r_odub_pend;
  logic [15:0]            r_new;
  logic [ACCESS_CYC-1:0]  r_idle_pipe;
  logic [15:0]            r_data;
  logic                   r_valid;
  logic                   r_loop_start;
  logic                   r_overrun;
  logic [ADDR_W-1:0]      r_sram_addr;
  logic [15:0]            r_dq_out;
  logic                   r_dq_oe;
  logic                   r_we_n;
  logic                   r_ce_n;
  logic                   r_oe_n;

  logic                   w_rec_req;
  logic                   w_odub_req;
  mode_t                  w_mode;
  logic [ADDR_W:0]        w_addr;
  logic [ADDR_W:0]        w_len;
  logic                   w_play_wrap;
  logic [ADDR_W:0]        w_play_next;
  logic [15:0]            w_sum;

  // Mode/address/length that apply if pending toggles are taken this cycle.
  always_comb begin
    w_rec_req  = r_rec_pend | i_rec_toggle;
    w_odub_req = r_odub_pend | i_odub_toggle;
    w_mode     = r_mode;
    w_addr     = r_addr;
    w_len      = r_loop_len;
    if (w_rec_req) begin
      // A record toggle takes precedence over a simultaneous overdub toggle.
      case (r_mode)
        M_IDLE: begin
          w_mode = M_RECORD;
          w_addr = '0;
          w_len  = '0;
        end
        M_RECORD: begin
          w_addr = '0;
          if (r_addr == '0) begin
            w_mode = M_IDLE;
            w_len  = '0;
          end else begin
            w_mode = M_PLAY;
            w_len  = r_addr;
          end
        end
        default: begin
          w_mode = M_IDLE;
          w_addr = '0;
        end
      endcase
    end else if (w_odub_req) begin
      case (r_mode)
        M_PLAY:  w_mode = M_ODUB;
        M_ODUB:  w_mode = M_PLAY;
        default: w_mode = r_mode;
      endcase
    end else begin
      w_mode = r_mode;
    end
    w_play_wrap = ((r_addr + ADDR_ONE) == r_loop_len);
    w_play_next = w_play_wrap ? '0 : (r_addr + ADDR_ONE);
    w_sum       = sat16(r_new, i_sram_dq_in);
  end

  // Loop mode, access sequencer and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_mode       <= M_IDLE;
      r_acc        <= A_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_loop_len   <= '0;
      r_rec_pend   <= 1'b0;
      r_odub_pend  <= 1'b0;
      r_new        <= 16'h0000;
      r_idle_pipe  <= '0;
      r_data       <= 16'h0000;
      r_valid      <= 1'b0;
      r_loop_start <= 1'b0;
      r_overrun    <= 1'b0;
      r_sram_addr  <= '0;
      r_dq_out     <= 16'h0000;
      r_dq_oe      <= 1'b0;
      r_we_n       <= 1'b1;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
    end else begin
      r_valid      <= 1'b0;
      r_loop_start <= 1'b0;
      r_idle_pipe  <= {r_idle_pipe[ACCESS_CYC-2:0], 1'b0};
      r_rec_pend   <= r_rec_pend | i_rec_toggle;
      r_odub_pend  <= r_odub_pend | i_odub_toggle;
      if (r_idle_pipe[ACCESS_CYC-1]) begin
        r_valid <= 1'b1;
        r_data  <= 16'h0000;
      end
      if (i_sample_valid && (r_acc != A_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_acc)
        A_IDLE: begin
          r_rec_pend  <= 1'b0;
          r_odub_pend <= 1'b0;
          r_mode      <= w_mode;
          r_addr      <= w_addr;
          r_loop_len  <= w_len;
          if (i_sample_valid) begin
            r_new       <= i_data;
            r_cnt       <= '0;
            r_sram_addr <= w_addr[ADDR_W-1:0];
            case (w_mode)
              M_RECORD: begin
                r_acc    <= A_WRITE;
                r_dq_out <= i_data;
                r_dq_oe  <= 1'b1;
                r_ce_n   <= 1'b0;
                r_we_n   <= 1'b0;
                r_oe_n   <= 1'b1;
              end
              M_PLAY, M_ODUB: begin
                r_acc  <= A_READ;
                r_ce_n <= 1'b0;
                r_oe_n <= 1'b0;
              end
              default: r_idle_pipe[0] <= 1'b1;
            endcase
          end
        end
        A_READ: begin
          if (r_cnt == LAST_CNT) begin
            r_valid <= 1'b1;
            r_data  <= i_sram_dq_in;
            r_cnt   <= '0;
            if (r_mode == M_ODUB) begin
              // Write back at the same address; r_sram_addr is left untouched.
              r_acc    <= A_WRITE;
              r_dq_out <= w_sum;
              r_dq_oe  <= 1'b1;
              r_oe_n   <= 1'b1;
              r_we_n   <= 1'b0;
            end else begin
              r_acc        <= A_IDLE;
              r_ce_n       <= 1'b1;
              r_oe_n       <= 1'b1;
              r_addr       <= w_play_next;
              r_loop_start <= w_play_wrap;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        A_WRITE: begin
          if (r_cnt == LAST_CNT) begin
            r_acc   <= A_IDLE;
            r_cnt   <= '0;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            if (r_mode == M_RECORD) begin
              r_valid <= 1'b1;
              r_data  <= 16'h0000;
              if ((r_addr + ADDR_ONE) == MAX_LEN_V) begin
                r_mode     <= M_PLAY;
                r_loop_len <= MAX_LEN_V;
                r_addr     <= '0;
              end else begin
                r_addr <= r_addr + ADDR_ONE;
              end
            end else begin
              r_addr       <= w_play_next;
              r_loop_start <= w_play_wrap;
            end
          end else begin
            // we_n rises for the final cycle so data is held past the write strobe.
            r_cnt  <= r_cnt + CNT_ONE;
            r_we_n <= (r_cnt == HOLD_PREV);
          end
        end
        default: begin
          r_acc   <= A_IDLE;
          r_cnt   <= '0;
          r_ce_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_dq_oe <= 1'b0;
        end
      endcase
    end
  end

  assign o_data        = r_data;
  assign o_valid       = r_valid;
  assign o_state       = r_mode;
  assign o_loop_len    = r_loop_len;
  assign o_loop_start  = r_loop_start;
  assign o_overrun     = r_overrun;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_dq_out = r_dq_out;
  assign o_sram_dq_oe  = r_dq_oe;
  assign o_sram_we_n   = r_we_n;
  assign o_sram_ce_n   = r_ce_n;
  assign o_sram_oe_n   = r_oe_n;
  assign o_sram_lb_n   = r_ce_n;
  assign o_sram_ub_n   = r_ce_n;

endmodule

// File: tb/tb_loop_sram_ctrl.sv
// Scoreboard bench for loop_sram_ctrl with a small SRAM model (MAX_LEN=8, ACCESS_CYC=2).
module tb_loop_sram_ctrl;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_sample_valid = 1'b0;
  logic [15:0]   i_data = 16'h0000;
  logic          i_rec_toggle = 1'b0;
  logic          i_odub_toggle = 1'b0;
  logic          i_clear = 1'b0;
  logic [15:0]   o_data;
  logic          o_valid;
  logic [1:0]    o_state;
  logic [AW:0]   o_loop_len;
  logic          o_loop_start;
  logic          o_overrun;
  logic [AW-1:0] o_sram_addr;
  logic [15:0]   o_sram_dq_out;
  logic          o_sram_dq_oe;
  logic [15:0]   i_sram_dq_in;
  logic          o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n;

  loop_sram_ctrl #(.ADDR_W(AW), .MAX_LEN(8), .ACCESS_CYC(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sample_valid(i_sample_valid), .i_data(i_data),
    .i_rec_toggle(i_rec_toggle), .i_odub_toggle(i_odub_toggle), .i_clear(i_clear),
    .o_data(o_data), .o_valid(o_valid), .o_state(o_state), .o_loop_len(o_loop_len),
    .o_loop_start(o_loop_start), .o_overrun(o_overrun), .o_sram_addr(o_sram_addr),
    .o_sram_dq_out(o_sram_dq_out), .o_sram_dq_oe(o_sram_dq_oe), .i_sram_dq_in(i_sram_dq_in),
    .o_sram_we_n(o_sram_we_n), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [15:0] mem [0:15];
  assign i_sram_dq_in = (!o_sram_oe_n && !o_sram_ce_n) ? mem[o_sram_addr] : 16'h0000;

  typedef struct { logic [15:0] data; int due; } out_t;
  typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
  out_t outq[$];
  wr_t  wrq[$];

  int checks = 0;
  int errors = 0;
  int ls_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every o_valid pops one expected sample and its due cycle.
  initial begin
    out_t e;
    forever begin
      @(negedge i_clk);
      if (o_valid) begin
        if (outq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got data 0x%0h at cycle %0d, expected no output", o_data, cyc);
        end else begin
          e = outq.pop_front();
          chk("out_data", {16'h0000, o_data}, {16'h0000, e.data});
          chk("out_cycle", cyc, e.due);
        end
      end
      if (o_loop_start) ls_cnt++;
    end
  end

  // SRAM model and write monitor: protocol of each write phase plus expected writes.
  initial begin
    logic          prev_we_low;
    logic [AW-1:0] prev_addr;
    logic [15:0]   prev_dq;
    int            last_rd;
    wr_t           w;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    prev_we_low = 1'b0;
    prev_addr   = '0;
    prev_dq     = 16'h0000;
    last_rd     = -1;
    forever begin
      @(negedge i_clk);
      if (!o_sram_ce_n && !o_sram_oe_n) last_rd = int'(o_sram_addr);
      if (prev_we_low && !o_sram_ce_n) begin
        chk("wr_hold_we_n", o_sram_we_n, 1);
        chk("wr_hold_dq_oe", o_sram_dq_oe, 1);
        chk("wr_hold_addr", o_sram_addr, prev_addr);
        chk("wr_hold_data", o_sram_dq_out, prev_dq);
      end
      if (!o_sram_we_n) begin
        chk("wr_we_single_cycle", prev_we_low, 0);
        chk("wr_ctrl_ce_oe_lb_ub_dqoe", {o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}, 5'b01001);
        if (o_state == 2'd3) chk("odub_read_before_write", last_rd, int'(o_sram_addr));
        last_rd = -1;
        if (wrq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got write 0x%0h at addr %0d, expected no write", o_sram_dq_out, o_sram_addr);
        end else begin
          w = wrq.pop_front();
          chk("wr_addr", o_sram_addr, w.addr);
          chk("wr_data", o_sram_dq_out, w.data);
        end
        mem[o_sram_addr] = o_sram_dq_out;
      end
      prev_we_low = !o_sram_we_n;
      prev_addr   = o_sram_addr;
      prev_dq     = o_sram_dq_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] d, input logic [15:0] exp_out, input bit expect_out);
    out_t e;
    if (expect_out) begin
      e.data = exp_out;
      e.due  = cyc + 3;
      outq.push_back(e);
    end
    i_sample_valid = 1'b1;
    i_data = d;
    tick(1);
    i_sample_valid = 1'b0;
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wrq.push_back(w);
  endtask

  task automatic pulse_rec();
    i_rec_toggle = 1'b1;
    tick(1);
    i_rec_toggle = 1'b0;
  endtask

  task automatic pulse_odub();
    i_odub_toggle = 1'b1;
    tick(1);
    i_odub_toggle = 1'b0;
  endtask

  logic [15:0] rec_vals [5]  = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
  logic [15:0] play_exp [12] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd100,
                                 16'd200, 16'd300, 16'd400, 16'd500, 16'd100, 16'd200};
  logic [15:0] od_in  [12] = '{16'd700, 16'd0, 16'd0, 16'hFFFB, 16'd0, 16'd32000,
                               16'h8000, 16'd0, 16'd0, 16'd0, 16'd100, 16'hFC18};
  logic [15:0] od_out [12] = '{16'd300, 16'd400, 16'd500, 16'd100, 16'd200, 16'd1000,
                               16'd400, 16'd500, 16'd95, 16'd200, 16'd32767, 16'h8190};
  logic [AW-1:0] od_wa [12] = '{4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3};
  logic [15:0] od_wd  [12] = '{16'd1000, 16'd400, 16'd500, 16'd95, 16'd200, 16'd32767,
                               16'h8190, 16'd500, 16'd95, 16'd200, 16'd32767, 16'h8000};

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while reset is held and just after release.
    tick(3);
    chk("rst_ctrl_we_ce_oe_lb_ub_dqoe", {o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}, 6'b111110);
    chk("rst_state", o_state, 2'd0);
    chk("rst_loop_len", o_loop_len, 5'd0);
    chk("rst_out", {o_valid, o_loop_start, o_overrun, o_data}, 19'd0);
    i_rst = 1'b0;
    tick(1);
    chk("idle_ctrl", {o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}, 6'b111110);

    // Idle: zero output after ACCESS_CYC+1, overdub toggle ignored.
    strobe(16'd1234, 16'd0, 1'b1);
    tick(5);
    pulse_odub();
    chk("odub_ignored_idle", o_state, 2'd0);

    // Record five samples, then toggle to play.
    pulse_rec();
    chk("rec_state", o_state, 2'd1);
    chk("rec_loop_len", o_loop_len, 5'd0);
    for (int i = 0; i < 5; i++) begin
      exp_wr(AW'(i), rec_vals[i]);
      strobe(rec_vals[i], 16'd0, 1'b1);
      tick(5);
    end
    pulse_rec();
    chk("play_state", o_state, 2'd2);
    chk("play_loop_len", o_loop_len, 5'd5);

    // Playback with two wraps.
    ls_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      strobe(16'd0, play_exp[i], 1'b1);
      tick(5);
    end
    chk("play_loop_starts", ls_cnt, 2);

    // Overdub starting at address 2, including positive and negative clamps.
    pulse_odub();
    chk("odub_state", o_state, 2'd3);
    ls_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      exp_wr(od_wa[i], od_wd[i]);
      strobe(od_in[i], od_out[i], 1'b1);
      tick(5);
    end
    chk("odub_loop_starts", ls_cnt, 2);
    pulse_odub();
    chk("odub_back_to_play", o_state, 2'd2);
    pulse_rec();
    chk("play_to_idle_state", o_state, 2'd0);
    chk("play_to_idle_len_kept", o_loop_len, 5'd5);

    // Record until full: auto play with loop length MAX_LEN.
    pulse_rec();
    chk("rec2_state", o_state, 2'd1);
    chk("rec2_len_zero", o_loop_len, 5'd0);
    for (int i = 0; i < 8; i++) begin
      exp_wr(AW'(i), 16'(i + 1));
      strobe(16'(i + 1), 16'd0, 1'b1);
      tick(5);
    end
    chk("full_auto_play", o_state, 2'd2);
    chk("full_loop_len", o_loop_len, 5'd8);

    // Second strobe during a busy read is dropped and flags overrun.
    chk("overrun_clear_before", o_overrun, 1'b0);
    strobe(16'd11, 16'd1, 1'b1);
    i_sample_valid = 1'b1;
    i_data = 16'd22;
    tick(1);
    i_sample_valid = 1'b0;
    tick(5);
    chk("overrun_set", o_overrun, 1'b1);

    // Clear, empty recording, then record toggle arriving mid-write.
    i_clear = 1'b1;
    tick(1);
    i_clear = 1'b0;
    chk("clear_state", o_state, 2'd0);
    chk("clear_len", o_loop_len, 5'd0);
    chk("clear_overrun", o_overrun, 1'b0);
    pulse_rec();
    chk("rec3_state", o_state, 2'd1);
    pulse_rec();
    chk("rec_empty_to_idle", o_state, 2'd0);
    chk("rec_empty_len", o_loop_len, 5'd0);
    pulse_rec();
    exp_wr(AW'(0), 16'd77);
    strobe(16'd77, 16'd0, 1'b1);
    i_rec_toggle = 1'b1;
    tick(1);
    i_rec_toggle = 1'b0;
    chk("rec_toggle_deferred", o_state, 2'd1);
    tick(3);
    chk("rec_toggle_applied", o_state, 2'd2);
    chk("rec_toggle_len", o_loop_len, 5'd1);

    // Clear in the middle of a read aborts it with no output.
    strobe(16'd0, 16'd0, 1'b0);
    i_clear = 1'b1;
    tick(1);
    i_clear = 1'b0;
    chk("clear_mid_read_ctrl", {o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}, 6'b111110);
    chk("clear_mid_read_state", o_state, 2'd0);
    chk("clear_mid_read_len", o_loop_len, 5'd0);
    tick(6);

    // Reset in the middle of a record write, with overrun pending.
    pulse_rec();
    exp_wr(AW'(0), 16'd55);
    strobe(16'd55, 16'd0, 1'b0);
    i_sample_valid = 1'b1;
    tick(1);
    i_sample_valid = 1'b0;
    chk("rec_overrun_set", o_overrun, 1'b1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    chk("rst_mid_rec_ctrl", {o_sram_we_n, o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}, 6'b111110);
    chk("rst_mid_rec_state", o_state, 2'd0);
    chk("rst_mid_rec_len", o_loop_len, 5'd0);
    chk("rst_mid_rec_addr", o_sram_addr, 4'd0);
    chk("rst_mid_rec_out", {o_valid, o_overrun, o_data}, 18'd0);
    tick(8);

    chk("out_queue_empty", outq.size(), 0);
    chk("wr_queue_empty", wrq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
